// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, load funct3 and writeback state definitions
//
// Purpose: constants and types used by the writeback stage and its load
// extractor.
// Ports: none (package).
package core_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_t;

   // Stores and branches never produce a register result.
   function automatic logic op_writes_rd(input logic [6:0] op);
      return !((op == OP_STORE) || (op == OP_BRANCH));
   endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational load data align, size and extend
//
// Purpose: shifts the raw aligned memory word down to the addressed byte
// and sizes/extends it according to the load funct3.
// Ports:
//   rdata_i  [XLEN-1:0]  raw aligned load word
//   off_i    [OW-1:0]    byte offset within the word
//   funct3_i [2:0]       load size/sign encoding
//   data_o   [XLEN-1:0]  extracted writeback value
module load_extract
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]              rdata_i,
   input  logic [$clog2(XLEN/8)-1:0]    off_i,
   input  logic [2:0]                   funct3_i,
   output logic [XLEN-1:0]              data_o
);

   logic [XLEN-1:0] sh;

   assign sh = rdata_i >> {off_i, 3'b000};

   // Size casts of $signed operands sign-extend; of unsigned operands zero-extend.
   always_comb begin
      data_o = XLEN'(sh[31:0]);
      case (funct3_i)
         F3_LB:   data_o = XLEN'($signed(sh[7:0]));
         F3_LH:   data_o = XLEN'($signed(sh[15:0]));
         F3_LW:   data_o = XLEN'($signed(sh[31:0]));
         F3_LBU:  data_o = XLEN'(sh[7:0]);
         F3_LHU:  data_o = XLEN'(sh[15:0]);
         // LD and LWU only exist on RV64; on RV32 they fall back to LW.
         F3_LD:   data_o = (XLEN == 64) ? sh : XLEN'($signed(sh[31:0]));
         F3_LWU:  data_o = (XLEN == 64) ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
         default: data_o = XLEN'(sh[31:0]);
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB boundary register and writeback source select
//
// Purpose: accepts instructions from MEM, selects the writeback value by
// opcode, waits for variable-latency load data and drives the register
// file write port (also used as the forwarding tap).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_valid / wb_ready  MEM handshake; transfer when both high
//   mem_ir, mem_pc        instruction word and its PC
//   mem_alu_out           ALU result, also load byte address
//   mem_imm               decoded U-immediate
//   flush                 kill pending or presented instruction
//   dmem_rvalid/rdata     load data response
//   rf_we/waddr/wdata     register file write port (one-cycle pulse)
//   wb_err                one-cycle pulse on load timeout
module wb_stage
   import core_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   output logic            wb_ready,
   input  logic [31:0]     mem_ir,
   input  logic [XLEN-1:0] mem_pc,
   input  logic [XLEN-1:0] mem_alu_out,
   input  logic [XLEN-1:0] mem_imm,
   input  logic            flush,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_err
);

   localparam int OW = $clog2(XLEN/8);

   wb_state_t       state_q, state_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      f3_q, f3_d;
   logic [OW-1:0]   off_q, off_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            wb_err_q, wb_err_d;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] src;

   logic [6:0] opcode;
   logic [4:0] ir_rd;
   logic [2:0] ir_f3;
   logic       unused_ir;

   assign opcode    = mem_ir[6:0];
   assign ir_rd     = mem_ir[11:7];
   assign ir_f3     = mem_ir[14:12];
   assign unused_ir = ^mem_ir[31:15];

   assign wb_ready = (state_q == IDLE);
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign wb_err   = wb_err_q;

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .rdata_i  (dmem_rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (load_data)
   );

   always_comb begin
      src = mem_alu_out;
      case (opcode)
         OP_LUI:          src = mem_imm;
         OP_JAL, OP_JALR: src = mem_pc + XLEN'(4);
         default:         src = mem_alu_out;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      f3_d       = f3_q;
      off_d      = off_q;
      cnt_d      = cnt_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      wb_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // A flushed instruction still handshakes but is dropped.
            if (mem_valid && !flush) begin
               if (opcode == OP_LOAD) begin
                  state_d = WAIT;
                  rd_d    = ir_rd;
                  f3_d    = ir_f3;
                  off_d   = mem_alu_out[OW-1:0];
                  cnt_d   = '0;
               end else if (op_writes_rd(opcode) && (ir_rd != 5'd0)) begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = ir_rd;
                  rf_wdata_d = src;
               end
            end
         end
         WAIT: begin
            // Priority: flush, then returning data, then timeout.
            if (flush) begin
               state_d = IDLE;
            end else if (dmem_rvalid) begin
               state_d = IDLE;
               if (rd_q != 5'd0) begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rd_q;
                  rf_wdata_d = load_data;
               end
            end else if ((LOAD_TIMEOUT != 0) && (cnt_q == 32'(LOAD_TIMEOUT - 1))) begin
               state_d  = IDLE;
               wb_err_d = 1'b1;
            end else if (LOAD_TIMEOUT != 0) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         cnt_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
      end
   end

endmodule
